lanternfish_feeder: RTL and testbench

//   Upstream stage of the lanternfish solver. Accepts the puzzle input as an

---
 rtl/lanternfish_feeder.sv | 221 ++++++++++++++++++++++
 tb/tb_lanternfish_feeder.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lanternfish_feeder.sv
// ============================================================================
// lanternfish_feeder
// ----------------------------------------------------------------------------
// Upstream stage of the lanternfish solver. Parses the puzzle input, an ASCII
// byte stream such as "3,4,3,1,2\n", arriving over a valid/ready handshake.
// Each timer digit becomes a one-cycle insert pulse carrying its value. Once
// the end of the stream is seen, the feeder issues DAYS advance pulses on
// consecutive cycles and then raises done, which it holds until reset. From
// that point on the solver's answer is final.
//
// Parameters
//   DAYS       number of advance pulses issued after end-of-input (0 allowed)
//   DAY_W      width of the day counter and day_count (2^DAY_W > DAYS)
//
// Ports
//   clk        in   1      single clock, rising edge
//   reset      in   1      asynchronous, active-high; clears all state
//   in_valid   in   1      in_data / in_last are valid
//   in_ready   out  1      feeder accepts a byte this cycle (PARSE only)
//   in_data    in   8      ASCII input byte
//   in_last    in   1      marks the final byte of the stream
//   insert     out  1      one-cycle pulse to the solver: add one fish
//   value      out  4      timer value of the inserted fish, 0 when idle
//   advance    out  1      one-cycle pulse to the solver: advance one day
//   busy       out  1      high while advance pulses are being issued
//   done       out  1      high once all DAYS advances are issued; held
//   day_count  out  DAY_W  number of advance pulses issued so far
//   error      out  1      (LANTERNFISH_FEEDER_ERROR_EN only) malformed input
//
// Build option
//   LANTERNFISH_FEEDER_ERROR_EN
//     Defined:     the error port and an ERROR state exist. '9', any byte
//                  that is not a digit/separator/newline, or a digit that
//                  directly follows another digit stops the feeder in ERROR
//                  with error held high until reset.
//     Not defined: such bytes are silently ignored and adjacent digits are
//                  inserted as separate fish ("34" gives 3 then 4).
//
// All outputs are registered except in_ready, which is decoded from state.
// ============================================================================
module lanternfish_feeder #(
    parameter int DAYS  = 80,
    parameter int DAY_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             insert,
    output logic [3:0]       value,
    output logic             advance,
    output logic             busy,
    output logic             done,
    output logic [DAY_W-1:0] day_count
`ifdef LANTERNFISH_FEEDER_ERROR_EN
    ,
    output logic             error
`endif
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] S_PARSE   = 2'd0;
    localparam logic [1:0] S_ADVANCE = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;
`ifdef LANTERNFISH_FEEDER_ERROR_EN
    localparam logic [1:0] S_ERROR   = 2'd3;
`endif

    // With zero days there is nothing to advance, so end-of-input goes
    // straight to DONE.
    localparam bit              NO_DAYS   = (DAYS == 0);
    localparam logic [DAY_W-1:0] DAYS_VAL = DAY_W'(DAYS);
    localparam logic [DAY_W-1:0] DAY_ONE  = DAY_W'(1);

    // ASCII codes recognised by the parser
    localparam logic [7:0] CH_ZERO    = 8'h30;
    localparam logic [7:0] CH_EIGHT   = 8'h38;
    localparam logic [7:0] CH_NEWLINE = 8'h0A;
`ifdef LANTERNFISH_FEEDER_ERROR_EN
    localparam logic [7:0] CH_COMMA   = 8'h2C;
    localparam logic [7:0] CH_SPACE   = 8'h20;
    localparam logic [7:0] CH_CR      = 8'h0D;
`endif

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]       r_state;
    logic             r_insert;
    logic [3:0]       r_value;
    logic             r_advance;
    logic             r_busy;
    logic             r_done;
    logic [DAY_W-1:0] r_day_count;
`ifdef LANTERNFISH_FEEDER_ERROR_EN
    logic             r_error;
    logic             r_prev_digit;
`endif

    // ------------------------------------------------------------------------
    // Byte classification
    // ------------------------------------------------------------------------
    logic       w_accept;
    logic       w_is_digit;
    logic       w_is_newline;
    logic       w_end_of_input;
    logic [3:0] w_digit_value;
`ifdef LANTERNFISH_FEEDER_ERROR_EN
    logic       w_is_separator;
    logic       w_bad_byte;
`endif

    assign in_ready       = (r_state == S_PARSE);
    assign w_accept       = in_valid && in_ready;
    assign w_is_digit     = (in_data >= CH_ZERO) && (in_data <= CH_EIGHT);
    assign w_is_newline   = (in_data == CH_NEWLINE);
    assign w_end_of_input = w_is_newline || in_last;
    // '0'..'8' are 0x30..0x38, so the low nibble is the timer value.
    assign w_digit_value  = in_data[3:0];

`ifdef LANTERNFISH_FEEDER_ERROR_EN
    assign w_is_separator = (in_data == CH_COMMA) || (in_data == CH_SPACE) ||
                            (in_data == CH_CR);
    // Anything outside the accepted alphabet, or two digits in a row, is a
    // malformed stream. A bad byte wins over in_last.
    assign w_bad_byte     = !(w_is_digit || w_is_separator || w_is_newline) ||
                            (w_is_digit && r_prev_digit);
`endif

    // ------------------------------------------------------------------------
    // Main sequencer: parses bytes into insert pulses, then counts out the
    // advance pulses and parks in DONE. insert and advance are one-cycle
    // pulses, so they default low on every clock.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_PARSE;
            r_insert    <= 1'b0;
            r_value     <= 4'd0;
            r_advance   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_day_count <= '0;
`ifdef LANTERNFISH_FEEDER_ERROR_EN
            r_error      <= 1'b0;
            r_prev_digit <= 1'b0;
`endif
        end else begin
            r_insert  <= 1'b0;
            r_value   <= 4'd0;
            r_advance <= 1'b0;

            case (r_state)
                S_PARSE: begin
                    if (w_accept) begin
`ifdef LANTERNFISH_FEEDER_ERROR_EN
                        r_prev_digit <= w_is_digit;
                        if (w_bad_byte) begin
                            r_state <= S_ERROR;
                            r_error <= 1'b1;
                        end else
`endif
                        begin
                            if (w_is_digit) begin
                                r_insert <= 1'b1;
                                r_value  <= w_digit_value;
                            end
                            // A digit carrying in_last is inserted above and
                            // the stream still ends here; the first advance
                            // then lands one cycle after that insert.
                            if (w_end_of_input) begin
                                if (NO_DAYS) begin
                                    r_state <= S_DONE;
                                    r_done  <= 1'b1;
                                end else begin
                                    r_state <= S_ADVANCE;
                                    r_busy  <= 1'b1;
                                end
                            end
                        end
                    end
                end

                S_ADVANCE: begin
                    // day_count already reflects the pulses issued, so once
                    // it reaches DAYS the last pulse has just finished.
                    if (r_day_count == DAYS_VAL) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_advance   <= 1'b1;
                        r_day_count <= r_day_count + DAY_ONE;
                    end
                end

                default: begin
                    // DONE and ERROR hold until reset.
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------------
    assign insert    = r_insert;
    assign value     = r_value;
    assign advance   = r_advance;
    assign busy      = r_busy;
    assign done      = r_done;
    assign day_count = r_day_count;
`ifdef LANTERNFISH_FEEDER_ERROR_EN
    assign error     = r_error;
`endif

endmodule

// File: tb/tb_lanternfish_feeder.sv
// ============================================================================
// tb_lanternfish_feeder
// ----------------------------------------------------------------------------
// Two feeders share one input stream: one with DAYS=80 and one with DAYS=0.
// A timing model tracks when the stream ends (or errors) and derives every
// output from that event time; a lanternfish population model is driven by
// the DAYS=80 feeder's pulses so the well-known puzzle answers (26 after 18
// days, 5934 after 80) pin the whole chain.
// ============================================================================
module tb_lanternfish_feeder;

    localparam int DAYS_A = 80;
    localparam int DAYS_B = 0;

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic        inValid = 1'b0;
    logic [7:0]  inData  = 8'h00;
    logic        inLast  = 1'b0;

    logic        ready80, insert80, advance80, busy80, done80;
    logic [3:0]  value80;
    logic [15:0] dayCount80;
    logic        ready0, insert0, advance0, busy0, done0;
    logic [3:0]  value0;
    logic [15:0] dayCount0;
`ifdef LANTERNFISH_FEEDER_ERROR_EN
    logic        error80, error0;
`endif

    int tests = 0;
    int fails = 0;

    // Timing model state (edge count since reset release, event edges)
    int cyc;
    int eoiAt;
    int errAt;
    bit prevDigit;
    bit expInsert;
    int expValue;

    // Population model fed by the DAYS=80 feeder
    longint fish [9];
    int     insSeq [$];
    int     advCnt80;
    int     advCnt0;

    always #5 clk = ~clk;

    lanternfish_feeder #(.DAYS(DAYS_A), .DAY_W(16)) dutA (
        .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(ready80),
        .in_data(inData), .in_last(inLast), .insert(insert80), .value(value80),
        .advance(advance80), .busy(busy80), .done(done80), .day_count(dayCount80)
`ifdef LANTERNFISH_FEEDER_ERROR_EN
        , .error(error80)
`endif
    );

    lanternfish_feeder #(.DAYS(DAYS_B), .DAY_W(16)) dutB (
        .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(ready0),
        .in_data(inData), .in_last(inLast), .insert(insert0), .value(value0),
        .advance(advance0), .busy(busy0), .done(done0), .day_count(dayCount0)
`ifdef LANTERNFISH_FEEDER_ERROR_EN
        , .error(error0)
`endif
    );

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Timing model: records which edge ended (or broke) the stream.
    // ------------------------------------------------------------------------
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc       <= 0;
            eoiAt     <= -1;
            errAt     <= -1;
            prevDigit <= 1'b0;
            expInsert <= 1'b0;
            expValue  <= 0;
        end else begin
            bit acc, isDigit, isSep, isNl, bad;
            acc     = inValid && (eoiAt < 0) && (errAt < 0);
            isDigit = (inData >= 8'h30) && (inData <= 8'h38);
            isSep   = (inData == 8'h2C) || (inData == 8'h20) || (inData == 8'h0D);
            isNl    = (inData == 8'h0A);
            bad     = 1'b0;
`ifdef LANTERNFISH_FEEDER_ERROR_EN
            bad = acc && ((!isDigit && !isSep && !isNl) || (isDigit && prevDigit));
`endif
            cyc <= cyc + 1;
            if (acc) prevDigit <= isDigit;
            if (bad) errAt <= cyc + 1;
            else if (acc && (isNl || inLast)) eoiAt <= cyc + 1;
            expInsert <= acc && isDigit && !bad;
            expValue  <= (acc && isDigit && !bad) ? int'(inData) - 48 : 0;
        end
    end

    function automatic bit expAdvance(input int d);
        return (eoiAt >= 0) && (cyc > eoiAt) && (cyc <= eoiAt + d);
    endfunction

    function automatic int expDay(input int d);
        if (eoiAt < 0) return 0;
        return (cyc - eoiAt < d) ? cyc - eoiAt : d;
    endfunction

    function automatic bit expBusy(input int d);
        return (d > 0) && (eoiAt >= 0) && (cyc <= eoiAt + d);
    endfunction

    function automatic bit expDone(input int d);
        return (eoiAt >= 0) && (cyc >= eoiAt + d + ((d > 0) ? 1 : 0));
    endfunction

    // ------------------------------------------------------------------------
    // Per-cycle comparison of both feeders against the timing model.
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        bit rdy;
        rdy = (eoiAt < 0) && (errAt < 0);
        checkOutput("ready80",    ready80,    rdy);
        checkOutput("insert80",   insert80,   expInsert);
        checkOutput("value80",    value80,    expValue);
        checkOutput("advance80",  advance80,  expAdvance(DAYS_A));
        checkOutput("busy80",     busy80,     expBusy(DAYS_A));
        checkOutput("done80",     done80,     expDone(DAYS_A));
        checkOutput("dayCount80", dayCount80, expDay(DAYS_A));
        checkOutput("ready0",     ready0,     rdy);
        checkOutput("insert0",    insert0,    expInsert);
        checkOutput("value0",     value0,     expValue);
        checkOutput("advance0",   advance0,   expAdvance(DAYS_B));
        checkOutput("busy0",      busy0,      expBusy(DAYS_B));
        checkOutput("done0",      done0,      expDone(DAYS_B));
        checkOutput("dayCount0",  dayCount0,  expDay(DAYS_B));
        checkOutput("no_overlap", insert80 & advance80, 0);
`ifdef LANTERNFISH_FEEDER_ERROR_EN
        checkOutput("error80", error80, errAt >= 0);
        checkOutput("error0",  error0,  errAt >= 0);
`endif
    end

    // ------------------------------------------------------------------------
    // Lanternfish population driven by the DAYS=80 feeder's pulses.
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < 9; i++) fish[i] = 0;
            insSeq.delete();
            advCnt80 = 0;
            advCnt0  = 0;
        end else begin
            if (insert80) begin
                insSeq.push_back(int'(value80));
                if (value80 <= 4'd8) fish[value80] = fish[value80] + 1;
            end
            if (advance80) begin
                longint n0;
                n0 = fish[0];
                for (int i = 0; i < 8; i++) fish[i] = fish[i + 1];
                fish[6] = fish[6] + n0;
                fish[8] = n0;
            end
            advCnt80 += int'(advance80);
            advCnt0  += int'(advance0);
        end
    end

    function automatic longint totalFish();
        longint t = 0;
        for (int i = 0; i < 9; i++) t += fish[i];
        return t;
    endfunction

    // ------------------------------------------------------------------------
    // Stimulus helpers. All start and end at posedge+1.
    // ------------------------------------------------------------------------
    task automatic applyStimulus(input logic [7:0] b, input logic last, input int maxGap);
        int  gap;
        int  waitCnt;
        bit  accepted;
        bit  rdy;
        gap      = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
        waitCnt  = 0;
        accepted = 0;
        inValid  = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        inValid = 1'b1;
        inData  = b;
        inLast  = last;
        while (!accepted && waitCnt < 50) begin
            @(negedge clk);
            rdy = ready80;
            @(posedge clk);
            #1;
            accepted = rdy;
            waitCnt++;
        end
        inValid = 1'b0;
        inLast  = 1'b0;
        if (!accepted) checkOutput("accept_timeout", 0, 1);
    endtask

    task automatic applyString(input string s, input bit lastOnFinal, input int maxGap);
        for (int i = 0; i < s.len(); i++)
            applyStimulus(s[i], lastOnFinal && (i == s.len() - 1), maxGap);
    endtask

    task automatic doReset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Ends at negedge+1 so population updates of that negedge are visible.
    task automatic waitDay(input int target, input int budget);
        int n = 0;
        do begin @(negedge clk); n++; end
        while (dayCount80 != 16'(target) && n < budget);
        #1;
        if (dayCount80 != 16'(target)) checkOutput("day_timeout", dayCount80, target);
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        do begin @(negedge clk); n++; end
        while (!done80 && n < budget);
        #1;
        if (!done80) checkOutput("done_timeout", done80, 1);
    endtask

    task automatic checkSeq(input string name, input int expSeq [$]);
        checkOutput({name, "_len"}, insSeq.size(), expSeq.size());
        for (int i = 0; i < expSeq.size() && i < insSeq.size(); i++)
            checkOutput({name, "_val"}, insSeq[i], expSeq[i]);
    endtask

    // ------------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------------
    initial begin
        // Reset state
        doReset();
        checkOutput("rst_ready",   ready80,    1);
        checkOutput("rst_done",    done80,     0);
        checkOutput("rst_day",     dayCount80, 0);
        checkOutput("rst_insert",  insert80,   0);

        // Example stream: 26 fish after 18 days, 5934 after 80
        applyString("3,4,3,1,2\n", 1'b0, 0);
        waitDay(18, 200);
        checkOutput("fish_day18", totalFish(), 26);
        waitDone(200);
        checkOutput("fish_day80", totalFish(), 5934);
        checkOutput("final_day",  dayCount80,  80);
        checkOutput("adv_count",  advCnt80,    80);
        checkOutput("zero_done",  done0,       1);
        checkOutput("zero_adv",   advCnt0,     0);
        checkSeq("seq_example", '{3, 4, 3, 1, 2});
        repeat (5) @(negedge clk);
        checkOutput("done_held", done80, 1);

        // Reset at day 5, then a clean re-run
        @(posedge clk); #1;
        doReset();
        applyString("3,4,3,1,2\n", 1'b0, 0);
        waitDay(5, 100);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("arst_insert",  insert80,   0);
        checkOutput("arst_advance", advance80,  0);
        checkOutput("arst_busy",    busy80,     0);
        checkOutput("arst_done",    done80,     0);
        checkOutput("arst_day",     dayCount80, 0);
        checkOutput("arst_ready",   ready80,    1);
        @(posedge clk); #1;
        doReset();
        applyString("3,4,3,1,2\n", 1'b0, 0);
        waitDone(200);
        checkOutput("refeed_fish", totalFish(), 5934);
        checkOutput("refeed_adv",  advCnt80,    80);

        // Gappy handshake, in_last on a digit
        @(posedge clk); #1;
        doReset();
        applyString("8,0", 1'b1, 3);
        waitDone(200);
        checkSeq("seq_last", '{8, 0});
        checkOutput("last_adv", advCnt80, 80);

        // Zero-day feeder: done the cycle after end-of-input
        @(posedge clk); #1;
        doReset();
        applyString("1\n", 1'b0, 0);
        @(negedge clk);
        #1;
        checkOutput("zd_done", done0,   1);
        checkOutput("zd_adv",  advCnt0, 0);
        checkSeq("seq_zd", '{1});
        waitDone(200);

        // Out-of-alphabet byte
        @(posedge clk); #1;
        doReset();
`ifdef LANTERNFISH_FEEDER_ERROR_EN
        applyString("3,9", 1'b0, 0);
        repeat (5) @(negedge clk);
        #1;
        checkOutput("err_flag",  error80, 1);
        checkOutput("err_done",  done80,  0);
        checkOutput("err_ready", ready80, 0);
        checkSeq("seq_err", '{3});
`else
        applyString("3,9\n", 1'b0, 0);
        waitDone(200);
        checkSeq("seq_nine", '{3});
        checkOutput("nine_adv",  advCnt80, 80);
        checkOutput("nine_done", done80,   1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
